hps_sw_poller: RTL and testbench
================================

# hps_sw_poller

Avalon-MM read master that periodically polls the 8-bit switch PIO input slave and republishes its value to fabric logic. It sits on the FPGA side of the Qsys/Platform Designer interconnect, driving the slave's `s1` port (address 0 = data register). It provides:

- a registered copy of the switch value,
- a one-cycle change strobe,
- a running sample count.

It tolerates `waitrequest` and a fixed, parameterised read latency.

## Interface
Parameters:
- `POLL_PERIOD`, 50000: idle cycles between the end of one read and the next request (≥1).
- `READ_LATENCY`, 1: fixed cycles from read acceptance to valid `avm_readdata` (0–7). The PIO slave uses 1.
- `DATA_WIDTH`, 8: switch bits taken from `avm_readdata[DATA_WIDTH-1:0]`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous reset, active-high.
- `avm_address` out 2: read address; constant 0.
- `avm_read` out 1: read request.
- `avm_readdata` in 32: slave read data.
- `avm_waitrequest` in 1: slave stall.
- `enable` in 1: permits periodic polling.
- `poll_now` in 1: one-cycle request for an immediate poll.
- `value` out DATA_WIDTH: last captured switch value.
- `value_valid` out 1: high once the first sample is captured.
- `changed` out 1: one-cycle pulse after a capture that differs from the previous `value`, or after the first capture.
- `sample_count` out 16: number of completed captures; wraps 0xFFFF→0.

## Operation
States:
- IDLE: timer loaded to POLL_PERIOD-1 on entry, decrements while `enable`=1, holds while `enable`=0.
  - → REQ when (`enable` and timer==0) or `poll_now`=1.
- REQ: `avm_read`=1, `avm_address`=0. The acceptance cycle is the cycle with `avm_read`=1 and `avm_waitrequest`=0.
  - Stay in REQ while `avm_waitrequest`=1. The read must not be dropped, even if `enable` falls.
  - On acceptance: if READ_LATENCY=0, capture on this edge and go → IDLE; else go → WAIT with latency counter = READ_LATENCY-1.
- WAIT: counter decrements each cycle. At counter==0, capture and go → IDLE.

Capture (one edge):
- `value` ← `avm_readdata[DATA_WIDTH-1:0]`; upper bits ignored.
- `value_valid` ← 1.
- `sample_count` += 1.
- `changed` ← 1 if (`value_valid`==0 or new≠old), else 0.
- `changed` is forced 0 on every non-capture edge.

Other rules:
- `poll_now` outside IDLE is ignored; it is not queued.
- `enable`=0 does not block `poll_now`.
- Reset in any state: synchronous, takes effect at the next edge. REQ/WAIT abandoned, `avm_read` deasserts that edge, any in-flight data is discarded.

## Timing
- Reset values: `avm_read`=0, `avm_address`=0, `value`=0, `value_valid`=0, `changed`=0, `sample_count`=0, state IDLE, timer=POLL_PERIOD-1.
- All outputs registered; no combinational path from inputs to outputs.
- With `enable` held high and `waitrequest`=0: first `avm_read` assertion is POLL_PERIOD cycles after reset release.
- Poll interval (acceptance to acceptance) = 1 + READ_LATENCY + POLL_PERIOD cycles, plus any `waitrequest` stall cycles.
- Capture edge = end of cycle (acceptance + READ_LATENCY). `value`/`changed` are visible in the following cycle.
- `poll_now` sampled high in IDLE → `avm_read` high the next cycle.

## Test plan
1. Reset, `enable`=1, POLL_PERIOD=4, READ_LATENCY=1, slave returns 0x000000A5 → `avm_read` high in cycle 4 after reset release. Then:
   - `value`=0xA5, `value_valid`=1, `changed` pulses one cycle, `sample_count`=1.
   - Next acceptance 6 cycles after the first.
2. Switches held at 0xA5 for 3 polls, then 0x3C → `changed` stays 0 for polls 2–3 and pulses on poll 4. `sample_count`=4, `value`=0x3C.
3. `waitrequest` high for 5 cycles of a REQ → `avm_read` stays high and `avm_address`=0 throughout; capture occurs 1 cycle after `waitrequest` falls. Drop `enable` during the stall → the read still completes.
4. `enable`=0, `poll_now` pulse in IDLE → exactly one read, next cycle. `poll_now` during WAIT → no extra read.
5. READ_LATENCY=3, `avm_readdata`=0xFFFFFF81 valid only in cycle acceptance+3 (garbage otherwise) → `value`=0x81.
6. `reset` asserted during WAIT → next cycle all outputs at reset values, no capture. Separately, preload 0xFFFF samples → next capture wraps `sample_count` to 0.

Source files
------------

// File: rtl/hps_sw_poller.sv
// hps_sw_poller: Avalon-MM read master that periodically samples the switch PIO and republishes its value
module hps_sw_poller #(
  parameter int POLL_PERIOD  = 50000,
  parameter int READ_LATENCY = 1,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  enable,
  input  logic                  poll_now,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  value_valid,
  output logic                  changed,
  output logic [15:0]           sample_count
);
  localparam int TW = POLL_PERIOD > 1 ? $clog2(POLL_PERIOD) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            lat_q, lat_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  valid_q, valid_d, changed_q, changed_d;
  logic [15:0]           sample_count_q, sample_count_d;
  logic                  acc, cap;
  logic                  unused_rd;
  assign unused_rd    = ^avm_readdata;
  assign avm_address  = 2'd0;
  assign avm_read     = state_q == REQ;
  assign value        = value_q;
  assign value_valid  = valid_q;
  assign changed      = changed_q;
  assign sample_count = sample_count_q;
  // next state, poll timer, latency countdown and capture
  always_comb begin
    acc            = state_q == REQ && !avm_waitrequest;
    cap            = (acc && READ_LATENCY == 0) || (state_q == WAIT && lat_q == 3'd0);
    state_d        = state_q == IDLE ? (((enable && timer_q == '0) || poll_now) ? REQ : IDLE)
                   : state_q == REQ  ? (acc ? (READ_LATENCY == 0 ? IDLE : WAIT) : REQ)
                   : (lat_q == 3'd0 ? IDLE : WAIT);
    timer_d        = state_q != IDLE ? TW'(POLL_PERIOD - 1)
                   : (enable && timer_q != '0) ? timer_q - 1'b1 : timer_q;
    lat_d          = acc ? 3'(READ_LATENCY - 1) : state_q == WAIT ? lat_q - 3'd1 : lat_q;
    value_d        = cap ? avm_readdata[DATA_WIDTH-1:0] : value_q;
    valid_d        = valid_q | cap;
    changed_d      = cap && (!valid_q || avm_readdata[DATA_WIDTH-1:0] != value_q);
    sample_count_d = cap ? sample_count_q + 16'd1 : sample_count_q;
  end
  // state and published-value registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= TW'(POLL_PERIOD - 1);
      lat_q          <= 3'd0;
      value_q        <= '0;
      valid_q        <= 1'b0;
      changed_q      <= 1'b0;
      sample_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lat_q          <= lat_d;
      value_q        <= value_d;
      valid_q        <= valid_d;
      changed_q      <= changed_d;
      sample_count_q <= sample_count_d;
    end
  end
endmodule

// File: tb/tb_hps_sw_poller.sv
// tb_hps_sw_poller: randomized scoreboard bench for two poller configurations
module tb_hps_sw_poller;
  logic clk = 0, reset = 1, enable = 0, poll_now = 0;
  int total = 0, passed = 0;
  typedef struct {int cyc; logic [7:0] v; logic ch; logic [15:0] n;} exp_t;
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int P = g ? 3 : 4;
    localparam int L = g ? 3 : 1;
    logic [1:0] addr;
    logic rd, vv, chg;
    logic wr = 0;
    logic [31:0] rdata = 0;
    logic [7:0] val;
    logic [15:0] cnt;
    hps_sw_poller #(.POLL_PERIOD(P), .READ_LATENCY(L), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .avm_address(addr), .avm_read(rd), .avm_readdata(rdata),
      .avm_waitrequest(wr), .enable(enable), .poll_now(poll_now), .value(val),
      .value_valid(vv), .changed(chg), .sample_count(cnt));
    int phase = 0, en_cnt = 0, lat = 0, c = 0, skip = 0;
    logic [31:0] data = g ? 32'hFFFFFF81 : 32'h000000A5;
    logic [31:0] word = 0;
    logic [7:0] mval = 0;
    logic mvalid = 0;
    logic [15:0] mcnt = 0, prev = 0;
    exp_t q[$];
    initial begin
      logic s_rst, s_en, s_pn, s_wr;
      logic [31:0] tmp;
      exp_t e;
      forever begin
        @(posedge clk);
        s_rst = reset; s_en = enable; s_pn = poll_now; s_wr = wr; c++;
        @(negedge clk);
        if (s_rst) begin
          phase = 0; en_cnt = 0; q.delete(); mval = 0; mvalid = 0; mcnt = 0;
        end else if (phase == 0) begin
          if (s_pn || (s_en && en_cnt == P - 1)) phase = 1;
          else if (s_en) en_cnt++;
        end else if (phase == 1) begin
          if (!s_wr) begin
            e.cyc = c + L; e.v = data[7:0]; e.ch = !mvalid || data[7:0] != mval; e.n = mcnt + 16'd1;
            q.push_back(e);
            mval = e.v; mvalid = 1; mcnt = e.n; word = data; lat = L; phase = 2;
            tmp = $urandom;
            data = ($urandom_range(2) == 0) ? tmp : {tmp[31:8], data[7:0]};
          end
        end else begin
          lat--;
          if (lat == 0) begin phase = 0; en_cnt = 0; end
        end
        if (s_rst) begin
          chk("reset value", val, 0); chk("reset valid", vv, 0);
          chk("reset changed", chg, 0); chk("reset count", cnt, 0);
          prev = cnt;
        end else if (skip > 0) begin
          skip--; prev = cnt;
        end else if (cnt != prev) begin
          prev = cnt;
          if (q.size() == 0) chk("spurious capture", 1, 0);
          else begin
            e = q.pop_front();
            chk("capture cycle", c, e.cyc); chk("value", val, e.v); chk("changed", chg, e.ch);
            chk("sample_count", cnt, e.n); chk("value_valid", vv, 1);
          end
        end else begin
          chk("changed idle", chg, 0);
          if (q.size() != 0 && q[0].cyc <= c) begin
            chk("missed capture", 0, 1);
            void'(q.pop_front());
          end
        end
        chk("avm_read", rd, phase == 1);
        chk("avm_address", addr, 0);
        rdata = (phase == 2 && lat == 1) ? word : $urandom;
        wr = $urandom_range(3) == 0;
      end
    end
  end
  task automatic run_random(int n);
    repeat (n) begin
      @(negedge clk);
      enable = $urandom_range(4) != 0;
      poll_now = $urandom_range(9) == 0;
    end
  endtask
  initial begin
    int i;
    reset = 1; enable = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);
    run_random(1500);
    poll_now = 0; enable = 1;
    for (i = 0; i < 300 && !(gen[1].phase == 2 && gen[1].lat >= 2); i++) @(negedge clk);
    chk("reached wait", gen[1].phase == 2 && gen[1].lat >= 2, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    run_random(500);
    enable = 0; poll_now = 0;
    for (i = 0; i < 300 && gen[0].phase != 0; i++) @(negedge clk);
    chk("idle before preload", gen[0].phase, 0);
    @(negedge clk);
    force gen[0].dut.sample_count_q = 16'hFFFF;
    gen[0].mcnt = 16'hFFFF; gen[0].skip = 2;
    @(negedge clk);
    release gen[0].dut.sample_count_q;
    poll_now = 1;
    @(negedge clk);
    poll_now = 0;
    for (i = 0; i < 200 && gen[0].cnt != 0; i++) @(negedge clk);
    chk("count wrap", gen[0].cnt, 0);
    run_random(300);
    enable = 0; poll_now = 0;
    repeat (60) @(negedge clk);
    chk("queue0 drained", gen[0].q.size(), 0);
    chk("queue1 drained", gen[1].q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
